prbs_checker: RTL and testbench

Receive-side pattern checker for the optical link test path. It consumes the recovered serial bit stream at the far end of the channel model, aligns to the repeating 7-bit test pattern, and counts received bits and bit errors for BER measurement. The transmit-side pattern generator drives its output bit once per clock. The checker is programmed with the same 7-bit pattern and sits directly downstream of the channel/receiver stage.

---
 rtl/osc_link_pkg.sv | 24 ++
 rtl/sat_counter.sv | 28 ++
 rtl/prbs_checker.sv | 166 ++++++++++++++++
 tb/tb_prbs_checker.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_link_pkg.sv
// Shared definitions for the optical link test path.
//   PAT_LEN     : length of the repeating test pattern
//   chk_state_t : pattern checker alignment states
//   rotr7       : rotate a 7-bit pattern right by k (bit i of the result is p[(i+k) mod 7])
package osc_link_pkg;

  localparam int PAT_LEN = 7;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } chk_state_t;

  // Window content expected after the stream has delivered seven bits that
  // start at pattern[k]: the oldest bit (h[0]) is pattern[k].
  function automatic logic [PAT_LEN-1:0] rotr7(input logic [PAT_LEN-1:0] p,
                                               input logic [2:0]         k);
    logic [2*PAT_LEN-1:0] d;
    d = {p, p} >> k;
    return d[PAT_LEN-1:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : count one event
//   q          : count value, holds at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side pattern checker: aligns to a repeating 7-bit pattern, then
// counts checked bits and bit errors for BER measurement.
//   clk, rst_n : clock, asynchronous active-low reset
//   pattern    : expected pattern, pattern[0] transmitted first
//   in_bit     : received bit, sampled only when in_valid is high
//   in_valid   : qualifies in_bit; all state holds when low
//   clr_cnt    : synchronous clear of bit_cnt / err_cnt
//   locked     : checker aligned
//   bit_cnt    : valid bits checked while locked (saturating)
//   err_cnt    : errored bits while locked (saturating)
//   err_pulse  : one-cycle pulse per counted errored bit
module prbs_checker
  import osc_link_pkg::*;
#(
  parameter int VERIFY_LEN  = 14,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               in_bit,
  input  logic               in_valid,
  input  logic               clr_cnt,
  output logic               locked,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               err_pulse
);

  // vcnt only needs to reach VERIFY_LEN-1; perr only needs to reach LOSS_THRESH.
  localparam int VC_W = (VERIFY_LEN > 1) ? $clog2(VERIFY_LEN) : 1;
  localparam int PE_W = $clog2(LOSS_THRESH + 1);

  chk_state_t         state, state_next;
  logic [PAT_LEN-1:0] window, window_upd;
  logic [2:0]         fill, fill_upd;
  logic [2:0]         phase, phase_upd;
  logic [2:0]         match_k;
  logic               match_any;
  logic               mismatch;
  logic               loss;
  logic [VC_W-1:0]    vcnt;
  logic [PE_W-1:0]    perr, perr_inc;
  logic               locked_d, err_pulse_d;
  logic               bit_inc, err_inc;

  // Values the window, fill and phase take if the current bit is valid.
  assign window_upd = {in_bit, window[PAT_LEN-1:1]};
  assign fill_upd   = (fill == 3'(PAT_LEN)) ? fill : fill + 3'd1;
  assign phase_upd  = (phase == 3'(PAT_LEN - 1)) ? 3'd0 : phase + 3'd1;
  assign mismatch   = in_bit ^ pattern[phase];
  assign perr_inc   = perr + PE_W'(1);
  assign loss       = mismatch && (perr_inc == PE_W'(LOSS_THRESH));

  // Scan from the highest rotation down so the lowest matching k is left in
  // match_k; degenerate patterns therefore resolve to k = 0.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    match_any = 1'b0;
    match_k   = 3'd0;
    for (int k = PAT_LEN - 1; k >= 0; k--) begin
      if (window_upd == rotr7(pattern, 3'(k))) begin
        match_any = 1'b1;
        match_k   = 3'(k);
      end
    end
  end

  // State register plus the registered outputs derived from next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (in_valid) begin
      unique case (state)
        SEARCH: if (fill_upd == 3'(PAT_LEN) && match_any) state_next = VERIFY;
        VERIFY: begin
          if (mismatch)                             state_next = SEARCH;
          else if (vcnt == VC_W'(VERIFY_LEN - 1))   state_next = LOCKED;
        end
        LOCKED: if (loss) state_next = SEARCH;
        default: state_next = SEARCH;
      endcase
    end
  end

  // Output logic: counter enables and the next values of the output flops.
  always_comb begin
    bit_inc     = in_valid && (state == LOCKED);
    err_inc     = bit_inc && mismatch;
    err_pulse_d = err_inc && !clr_cnt;
    locked_d    = (state_next == LOCKED);
  end

  // Window, search fill, pattern phase, verify run length and per-period
  // error count. Nothing moves on cycles without a valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window <= '0;
      fill   <= '0;
      phase  <= '0;
      vcnt   <= '0;
      perr   <= '0;
    end else if (in_valid) begin
      window <= window_upd;
      unique case (state)
        SEARCH: begin
          fill <= fill_upd;
          if (state_next == VERIFY) begin
            phase <= match_k;
            vcnt  <= '0;
          end
        end
        VERIFY: begin
          phase <= phase_upd;
          vcnt  <= vcnt + VC_W'(1);
          if (state_next == SEARCH) fill <= '0;
          if (state_next == LOCKED) perr <= '0;
        end
        LOCKED: begin
          phase <= phase_upd;
          if (loss) begin
            fill <= '0;
            perr <= '0;
          end else if (phase == 3'(PAT_LEN - 1)) begin
            // A period ends on this bit; start the next one from zero errors.
            perr <= '0;
          end else if (mismatch) begin
            perr <= perr_inc;
          end
        end
        default: fill <= '0;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (bit_inc),
    .q     (bit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (err_inc),
    .q     (err_cnt)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker. A second, 4-bit-counter instance
// shares all inputs and is used for the saturation behaviour.
module tb_prbs_checker;

  localparam int VLEN = 14;
  localparam int LOSS = 3;

  logic        clk;
  logic        rst_n;
  logic [6:0]  pattern;
  logic        in_bit, in_valid, clr_cnt;
  logic        locked, err_pulse;
  logic [31:0] bit_cnt, err_cnt;
  logic        s_locked, s_err_pulse;
  logic [3:0]  s_bit_cnt, s_err_cnt;

  prbs_checker #(.VERIFY_LEN(VLEN), .LOSS_THRESH(LOSS), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .in_bit(in_bit),
    .in_valid(in_valid), .clr_cnt(clr_cnt), .locked(locked),
    .bit_cnt(bit_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse)
  );

  prbs_checker #(.VERIFY_LEN(VLEN), .LOSS_THRESH(LOSS), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .in_bit(in_bit),
    .in_valid(in_valid), .clr_cnt(clr_cnt), .locked(s_locked),
    .bit_cnt(s_bit_cnt), .err_cnt(s_err_cnt), .err_pulse(s_err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural reference model ----------------
  localparam int MD_SEARCH = 0, MD_VERIFY = 1, MD_LOCK = 2;
  bit       hist[$];     // last 7 valid bits, hist[0] oldest
  int       m_mode, m_fill, m_ph, m_run, m_perr;
  int       m_bits, m_errs;
  bit       m_pulse;
  bit [6:0] pat;
  int       tx_pos;      // index of the next pattern bit the transmitter sends

  function automatic bit aligned_at(int k);
    for (int i = 0; i < 7; i++)
      if (hist[i] != pat[(i + k) % 7]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_locked();
    return m_mode == MD_LOCK;
  endfunction

  function automatic logic [3:0] small_exp(int n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mode = MD_SEARCH; m_fill = 0; m_ph = 0; m_run = 0; m_perr = 0;
    m_bits = 0; m_errs = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit e;
    m_pulse = 1'b0;
    if (v) begin
      hist.push_back(b);
      if (hist.size() > 7) void'(hist.pop_front());
      case (m_mode)
        MD_SEARCH: begin
          if (m_fill < 7) m_fill++;
          if (m_fill == 7) begin
            for (int k = 0; k < 7; k++) begin
              if (aligned_at(k)) begin
                m_mode = MD_VERIFY; m_ph = k; m_run = 0;
                break;
              end
            end
          end
        end
        MD_VERIFY: begin
          e = (b != pat[m_ph]);
          m_ph = (m_ph + 1) % 7;
          if (e) begin
            m_mode = MD_SEARCH; m_fill = 0;
          end else begin
            m_run++;
            if (m_run == VLEN) begin m_mode = MD_LOCK; m_perr = 0; end
          end
        end
        default: begin
          e = (b != pat[m_ph]);
          if (!c) begin
            m_bits++;
            if (e) begin m_errs++; m_pulse = 1'b1; end
          end
          if (e) m_perr++;
          if (e && m_perr >= LOSS) begin
            m_mode = MD_SEARCH; m_fill = 0; m_perr = 0;
          end else if (m_ph == 6) begin
            m_perr = 0;
          end
          m_ph = (m_ph + 1) % 7;
        end
      endcase
    end
    if (c) begin m_bits = 0; m_errs = 0; end
  endtask

  // ---------------- stimulus helpers ----------------
  // Drive one cycle, advance the model on the edge, return 1 ns after it.
  task automatic tick(input bit b, input bit v, input bit c);
    in_bit = b; in_valid = v; clr_cnt = c;
    @(posedge clk);
    model_step(b, v, c);
    #1;
  endtask

  // Send the next transmitter bit, optionally inverted by the channel.
  task automatic send(input bit flip, input bit c = 1'b0);
    bit b;
    b = pat[tx_pos] ^ flip;
    tx_pos = (tx_pos + 1) % 7;
    tick(b, 1'b1, c);
  endtask

  task automatic do_reset(input logic [6:0] p);
    @(negedge clk);
    rst_n = 1'b0; pattern = p; pat = p;
    in_bit = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
    model_reset();
    tx_pos = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(7'b1001011);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    total++; if (bit_cnt !== 32'd0) begin bad++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse: got %0b want 0", err_pulse); end
  endtask

  task automatic test_clean();
    do_reset(7'b1001011);
    for (int i = 1; i <= 21; i++) begin
      send(1'b0);
      if (i == 20) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL clean_early_lock: locked=%0b at bit 20 want 0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_lock21: locked=%0b at bit 21 want 1", locked); end
    repeat (70) send(1'b0);
    total++; if (bit_cnt !== 32'd70) begin bad++; $display("FAIL clean_bit_cnt: got %0d want 70", bit_cnt); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_hold_lock: got %0b want 1", locked); end
  endtask

  task automatic test_phase_offset();
    do_reset(7'b1001011);
    tx_pos = 3;
    repeat (21) send(1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL offset_lock21: got %0b want 1", locked); end
    repeat (14) send(1'b0);
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL offset_err_cnt: got %0d want 0", err_cnt); end
    total++; if (bit_cnt !== 32'd14) begin bad++; $display("FAIL offset_bit_cnt: got %0d want 14", bit_cnt); end
    // Duplicated first bit, then an aligned stream from pattern[0].
    do_reset(7'b1001011);
    tick(pat[0], 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      send(1'b0);
      total++; if (locked !== m_locked()) begin bad++; $display("FAIL slide_track: bit %0d locked=%0b want %0b", i, locked, m_locked()); end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL slide_lock: got %0b want 1", locked); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL slide_err_cnt: got %0d want 0", err_cnt); end
  endtask

  // Runs on from the locked state left by test_phase_offset.
  task automatic test_single_error();
    send(1'b1);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL single_pulse: got %0b want 1", err_pulse); end
    total++; if (err_cnt !== 32'd1) begin bad++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL single_locked: got %0b want 1", locked); end
    send(1'b0);
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %0b want 0", err_pulse); end
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7 && m_ph != 0; i++) send(1'b0);
    // Errors at phases 0, 2 and 4 of one period.
    send(1'b1); send(1'b0); send(1'b1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL burst_two_errs: locked=%0b want 1", locked); end
    send(1'b0); send(1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL burst_loss: locked=%0b want 0", locked); end
    total++; if (err_cnt !== 32'd3) begin bad++; $display("FAIL burst_err_cnt: got %0d want 3", err_cnt); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL burst_pulse: got %0b want 1", err_pulse); end
    for (int i = 1; i <= 21; i++) begin
      send(1'b0);
      if (i == 20) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %0b want 0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock21: got %0b want 1", locked); end
  endtask

  task automatic test_verify_error();
    do_reset(7'b1001011);
    for (int i = 1; i <= 40; i++) begin
      send(i == 10);
      if (i == 21) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL verr_no_lock21: got %0b want 0", locked); end
      end
      if (!m_locked()) begin
        total++; if (bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin bad++; $display("FAIL verr_cnt_idle: bit %0d cnt=%0d/%0d want 0/0", i, bit_cnt, err_cnt); end
      end
      total++; if (locked !== m_locked()) begin bad++; $display("FAIL verr_track: bit %0d locked=%0b want %0b", i, locked, m_locked()); end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL verr_eventual_lock: got %0b want 1", locked); end
  endtask

  // Runs on from the locked state left by test_verify_error.
  task automatic test_valid_toggle();
    int n;
    n = 0;
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        send(1'b0); n++;
      end else begin
        tick(1'($urandom_range(1, 0)), 1'b0, 1'b0);
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL toggle_idle_pulse: got %0b want 0", err_pulse); end
      end
    end
    total++; if (bit_cnt !== 32'(n)) begin bad++; $display("FAIL toggle_bit_cnt: got %0d want %0d", bit_cnt, n); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL toggle_err_cnt: got %0d want 0", err_cnt); end
    send(1'b1, 1'b1);
    total++; if (bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin bad++; $display("FAIL clr_priority: cnt=%0d/%0d want 0/0", bit_cnt, err_cnt); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_keeps_lock: got %0b want 1", locked); end
    send(1'b0);
    total++; if (bit_cnt !== 32'd1) begin bad++; $display("FAIL clr_resume: got %0d want 1", bit_cnt); end
  endtask

  task automatic test_random(input logic [6:0] p);
    bit v, f, c;
    do_reset(p);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(3, 0) != 0);
      f = ($urandom_range(19, 0) == 0);
      c = ($urandom_range(49, 0) == 0);
      if (v) send(f, c);
      else   tick(1'($urandom_range(1, 0)), 1'b0, c);
      total++; if (locked !== m_locked()) begin bad++; $display("FAIL rand_locked: cyc %0d got %0b want %0b", i, locked, m_locked()); end
      total++; if (bit_cnt !== 32'(m_bits)) begin bad++; $display("FAIL rand_bit_cnt: cyc %0d got %0d want %0d", i, bit_cnt, m_bits); end
      total++; if (err_cnt !== 32'(m_errs)) begin bad++; $display("FAIL rand_err_cnt: cyc %0d got %0d want %0d", i, err_cnt, m_errs); end
      total++; if (err_pulse !== m_pulse) begin bad++; $display("FAIL rand_err_pulse: cyc %0d got %0b want %0b", i, err_pulse, m_pulse); end
      total++; if (s_bit_cnt !== small_exp(m_bits)) begin bad++; $display("FAIL rand_small_bit_cnt: cyc %0d got %0d want %0d", i, s_bit_cnt, small_exp(m_bits)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset(7'b1001011);
    repeat (31) send(1'b0);
    total++; if (locked !== 1'b1 || bit_cnt !== 32'd10) begin bad++; $display("FAIL arst_pre: locked=%0b cnt=%0d want 1/10", locked, bit_cnt); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL arst_locked: got %0b want 0", locked); end
    total++; if (bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin bad++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", bit_cnt, err_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      send(1'b0);
      if (i == 20) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL arst_early: got %0b want 0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL arst_relock: got %0b want 1", locked); end
    total++; if (bit_cnt !== 32'd0) begin bad++; $display("FAIL arst_cnt_resume: got %0d want 0", bit_cnt); end
  endtask

  task automatic test_zero_pattern();
    do_reset(7'b0000000);
    repeat (21) send(1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL zero_lock21: got %0b want 1", locked); end
    send(1'b1);
    total++; if (err_cnt !== 32'd1 || bit_cnt !== 32'd1) begin bad++; $display("FAIL zero_err: cnt=%0d/%0d want 1/1", bit_cnt, err_cnt); end
  endtask

  task automatic test_saturation();
    do_reset(7'b1001011);
    repeat (21) send(1'b0);
    repeat (20) send(1'b0);
    total++; if (bit_cnt !== 32'd20) begin bad++; $display("FAIL sat_wide: got %0d want 20", bit_cnt); end
    total++; if (s_bit_cnt !== 4'hF) begin bad++; $display("FAIL sat_small_hold: got %0d want 15", s_bit_cnt); end
    send(1'b1);
    total++; if (s_bit_cnt !== 4'hF || s_err_cnt !== 4'd1) begin bad++; $display("FAIL sat_small_err: got %0d/%0d want 15/1", s_bit_cnt, s_err_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; pattern = '0; in_bit = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
    pat = '0; tx_pos = 0;
    model_reset();
    test_reset();
    test_clean();
    test_phase_offset();
    test_single_error();
    test_verify_error();
    test_valid_toggle();
    test_random(7'b1001011);
    test_random(7'($urandom_range(126, 1)));
    test_async_reset();
    test_zero_pattern();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
